// File: rtl/skein_pkg.sv
// rtl/skein_pkg.sv - shared state encoding, sizes and length rounding for the Skein-256 message loader
package skein_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN,
    S_FILL,
    S_LOAD,
    S_START,
    S_WAIT,
    S_OUT_LOAD,
    S_OUT_START,
    S_OUT_WAIT,
    S_DONE
  } state_e;

  localparam int BLK_BITS      = 256;
  localparam int BLK_WORDS_DEF = 16;
  localparam int LEN_WORDS_DEF = 4;

  // Partial trailing byte counts as a whole byte.
  function automatic logic [60:0] bytes_from_bits(input logic [63:0] bits);
    return bits[63:3] + {60'd0, |bits[2:0]};
  endfunction

endpackage

// File: rtl/skein_msg_loader_if.sv
// rtl/skein_msg_loader_if.sv - host word stream handshake into the Skein-256 loader
interface skein_msg_loader_if;

  logic        host_init;
  logic        host_valid;
  logic [15:0] host_data;
  logic        host_ready;

  modport master (output host_init, output host_valid, output host_data, input host_ready);
  modport slave  (input host_init, input host_valid, input host_data, output host_ready);

endinterface

// File: rtl/skein_blk_buf.sv
// rtl/skein_blk_buf.sv - one 256-bit message block assembled from 16-bit words; clear wins over write
module skein_blk_buf
  import skein_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_i,
  input  logic                we_i,
  input  logic [3:0]          widx_i,
  input  logic [15:0]         wdata_i,
  output logic [BLK_BITS-1:0] blk_o
);

  logic [BLK_BITS-1:0] blk_q;
  logic [BLK_BITS-1:0] blk_d;

  always_comb begin
    blk_d = blk_q;
    if (clr_i) begin
      blk_d = '0;
    end else if (we_i) begin
      blk_d[{widx_i, 4'b0000} +: 16] = wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_q <= '0;
    end else begin
      blk_q <= blk_d;
    end
  end

  assign blk_o = blk_q;

endmodule

// File: rtl/skein_msg_loader.sv
// rtl/skein_msg_loader.sv - Skein-256 host loader: length capture, block fill/pad, core sequencing
// Define SKEIN_LDR_DBUF_EN to add a second fill buffer so the host keeps streaming during WAIT.
module skein_msg_loader
  import skein_pkg::*;
#(
  parameter int BLK_WORDS = BLK_WORDS_DEF,
  parameter int LEN_WORDS = LEN_WORDS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  skein_msg_loader_if.slave   host,
  output logic                hash_done,
  output logic                core_init,
  output logic                core_ld_posi,
  output logic [15:0]         core_idata,
  output logic                core_ld_tweak,
  output logic                core_start,
  input  logic                core_busy,
  output logic [63:0]         msg0,
  output logic [63:0]         msg1,
  output logic [63:0]         msg2,
  output logic [63:0]         msg3
);

`ifdef SKEIN_LDR_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  localparam int             LCW      = (LEN_WORDS > 1) ? $clog2(LEN_WORDS) : 1;
  localparam logic [LCW-1:0] LEN_LAST = LCW'(LEN_WORDS - 1);
  localparam logic [3:0]     BLK_LAST = 4'(BLK_WORDS - 1);

  state_e         state_q, state_d;
  logic [LCW-1:0] len_cnt_q, len_cnt_d;
  logic [47:0]    len_acc_q, len_acc_d;
  logic [59:0]    words_left_q, words_left_d;
  logic           odd_q, odd_d;
  logic [3:0]     wcnt_q, wcnt_d;
  logic           sel_q, sel_d;
  logic           nxt_full_q, nxt_full_d;
  logic           init_q, posi_q;
  logic [15:0]    idata_q;

  logic           ready, accept, wr_en, wr_sel, last_word, blk_end, buf_clr;
  logic [63:0]    len_bits;
  logic [60:0]    len_bytes;
  logic [15:0]    fill_word;
  logic [255:0]   blk0, active_blk;

  always_comb begin
    ready = 1'b0;
    case (state_q)
      S_LEN:   ready = 1'b1;
      S_FILL:  ready = (words_left_q != '0);
      S_WAIT:  ready = DBUF && (words_left_q != '0) && !nxt_full_q;
      default: ready = 1'b0;
    endcase
  end

  assign host.host_ready = ready;
  assign accept    = host.host_valid && ready && !host.host_init;
  assign wr_en     = accept && (state_q == S_FILL || state_q == S_WAIT);
  assign wr_sel    = (state_q == S_WAIT) ? ~sel_q : sel_q;
  assign last_word = (words_left_q == 60'd1);
  assign blk_end   = (wcnt_q == BLK_LAST) || last_word;
  assign len_bits  = {len_acc_q, host.host_data};
  assign len_bytes = bytes_from_bits(len_bits);
  // An odd byte count leaves the final word's upper (later) byte outside the message.
  assign fill_word = (last_word && odd_q) ? {8'h00, host.host_data[7:0]} : host.host_data;

  always_comb begin
    state_d      = state_q;
    len_cnt_d    = len_cnt_q;
    len_acc_d    = len_acc_q;
    words_left_d = words_left_q;
    odd_d        = odd_q;
    wcnt_d       = wcnt_q;
    sel_d        = sel_q;
    nxt_full_d   = nxt_full_q;
    buf_clr      = 1'b0;

    if (wr_en) begin
      words_left_d = (words_left_q != '0) ? words_left_q - 60'd1 : words_left_q;
      wcnt_d       = blk_end ? 4'd0 : wcnt_q + 4'd1;
    end

    unique case (state_q)
      S_IDLE: begin
      end
      S_LEN: begin
        if (accept) begin
          len_acc_d = len_bits[47:0];
          if (len_cnt_q == LEN_LAST) begin
            words_left_d = len_bytes[60:1] + {59'd0, len_bytes[0]};
            odd_d        = len_bytes[0];
            state_d      = (len_bytes == '0) ? S_LOAD : S_FILL;
          end else begin
            len_cnt_d = len_cnt_q + LCW'(1);
          end
        end
      end
      S_FILL: begin
        if ((wr_en && blk_end) || words_left_q == '0) state_d = S_LOAD;
      end
      S_LOAD:  state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        // The finished block leaves with the core; any pre-filled block becomes active.
        if (!core_busy) begin
          buf_clr    = 1'b1;
          sel_d      = DBUF ? ~sel_q : sel_q;
          nxt_full_d = 1'b0;
          if (nxt_full_q || (wr_en && blk_end)) state_d = S_LOAD;
          else if (words_left_q != '0)         state_d = S_FILL;
          else                                 state_d = S_OUT_LOAD;
        end else if (wr_en && blk_end) begin
          nxt_full_d = 1'b1;
        end
      end
      S_OUT_LOAD:  state_d = S_OUT_START;
      S_OUT_START: state_d = S_OUT_WAIT;
      S_OUT_WAIT: begin
        if (!core_busy) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (host.host_init) begin
      state_d      = S_LEN;
      len_cnt_d    = '0;
      len_acc_d    = '0;
      words_left_d = '0;
      odd_d        = 1'b0;
      wcnt_d       = '0;
      sel_d        = 1'b0;
      nxt_full_d   = 1'b0;
      buf_clr      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      len_cnt_q    <= '0;
      len_acc_q    <= '0;
      words_left_q <= '0;
      odd_q        <= 1'b0;
      wcnt_q       <= '0;
      sel_q        <= 1'b0;
      nxt_full_q   <= 1'b0;
      init_q       <= 1'b0;
      posi_q       <= 1'b0;
      idata_q      <= '0;
    end else begin
      state_q      <= state_d;
      len_cnt_q    <= len_cnt_d;
      len_acc_q    <= len_acc_d;
      words_left_q <= words_left_d;
      odd_q        <= odd_d;
      wcnt_q       <= wcnt_d;
      sel_q        <= sel_d;
      nxt_full_q   <= nxt_full_d;
      init_q       <= host.host_init;
      posi_q       <= accept && (state_q == S_LEN);
      if (accept && state_q == S_LEN) idata_q <= host.host_data;
    end
  end

  skein_blk_buf u_buf0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (host.host_init || (buf_clr && !sel_q)),
    .we_i    (wr_en && !wr_sel),
    .widx_i  (wcnt_q),
    .wdata_i (fill_word),
    .blk_o   (blk0)
  );

`ifdef SKEIN_LDR_DBUF_EN
  logic [255:0] blk1;

  skein_blk_buf u_buf1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (host.host_init || (buf_clr && sel_q)),
    .we_i    (wr_en && wr_sel),
    .widx_i  (wcnt_q),
    .wdata_i (fill_word),
    .blk_o   (blk1)
  );

  assign active_blk = sel_q ? blk1 : blk0;
`else
  assign active_blk = blk0;
`endif

  assign core_init     = init_q;
  assign core_ld_posi  = posi_q;
  assign core_idata    = idata_q;
  assign core_ld_tweak = (state_q == S_LOAD) || (state_q == S_OUT_LOAD);
  assign core_start    = (state_q == S_START) || (state_q == S_OUT_START);
  assign hash_done     = (state_q == S_DONE);
  assign msg0          = active_blk[63:0];
  assign msg1          = active_blk[127:64];
  assign msg2          = active_blk[191:128];
  assign msg3          = active_blk[255:192];

endmodule

// File: tb/tb_skein_msg_loader.sv
// tb/tb_skein_msg_loader.sv - scoreboard bench for skein_msg_loader with a byte-level hashing front-end model
module tb_skein_msg_loader;

  localparam int EV_INIT  = 0;
  localparam int EV_POSI  = 1;
  localparam int EV_TWEAK = 2;
  localparam int EV_DONE  = 3;

  typedef struct {
    int           kind;
    logic [255:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hash_done, core_init, core_ld_posi, core_ld_tweak, core_start, core_busy;
  logic [15:0] core_idata;
  logic [63:0] msg0, msg1, msg2, msg3;

  int  n_chk = 0;
  int  n_fail = 0;
  int  busy_cnt;
  int  busy_len = 0;
  int  tweaks_seen = 0;
  bit  chk_dbuf = 1'b0;
  ev_t exp_q[$];

  always #5 clk = ~clk;

  skein_msg_loader_if hif ();

  skein_msg_loader dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .host          (hif),
    .hash_done     (hash_done),
    .core_init     (core_init),
    .core_ld_posi  (core_ld_posi),
    .core_idata    (core_idata),
    .core_ld_tweak (core_ld_tweak),
    .core_start    (core_start),
    .core_busy     (core_busy),
    .msg0          (msg0),
    .msg1          (msg1),
    .msg2          (msg2),
    .msg3          (msg3)
  );

  // Core stand-in: busy covers the start cycle and a few cycles after it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)          busy_cnt <= 0;
    else if (core_start) busy_cnt <= (busy_len > 0) ? busy_len : int'($urandom_range(1, 6));
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign core_busy = core_start || (busy_cnt != 0);

  function automatic void chk(input string name, input logic [255:0] got, input logic [255:0] req);
    n_chk++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endfunction

  function automatic void pop_ev(input int kind, input logic [255:0] got, input string name);
    ev_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: unexpected event, got %h, required none", name, got);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.data !== got) begin
        n_fail++;
        $display("FAIL %s: got kind %0d data %h, required kind %0d data %h", name, kind, got, e.kind, e.data);
      end
    end
  endfunction

  function automatic void push_ev(input int kind, input logic [255:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a core-side event.
  initial begin
    bit           prev_tweak = 1'b0, prev_busy = 1'b0, in_wait = 1'b0;
    bit           want_ready = 1'b0, want_fast = 1'b0;
    logic [255:0] held_msg = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_tweak = 1'b0; prev_busy = 1'b0; in_wait = 1'b0; want_ready = 1'b0; want_fast = 1'b0;
      end else begin
        if (core_init) begin
          pop_ev(EV_INIT, '0, "core_init");
          in_wait = 1'b0;
        end
        if (core_ld_posi) pop_ev(EV_POSI, 256'(core_idata), "ld_posi idata");
        if (core_ld_tweak) begin
          pop_ev(EV_TWEAK, {msg3, msg2, msg1, msg0}, "ld_tweak msg");
          held_msg = {msg3, msg2, msg1, msg0};
          tweaks_seen++;
        end
        if (hash_done) pop_ev(EV_DONE, '0, "hash_done");
        if (core_start || prev_tweak) chk("start after tweak", 256'(core_start), 256'(prev_tweak));
        if (want_ready) begin
          chk("dbuf ready in wait", 256'(hif.host_ready), 256'd1);
          want_ready = 1'b0;
        end
        if (want_fast) begin
          chk("dbuf reload after busy fall", 256'(core_ld_tweak), 256'd1);
          want_fast = 1'b0;
        end
        if (core_start) begin
          in_wait = 1'b1;
          if (chk_dbuf && tweaks_seen == 1) want_ready = 1'b1;
        end
        if (in_wait && prev_busy && !core_busy) begin
          chk("msg stable in wait", {msg3, msg2, msg1, msg0}, held_msg);
          if (chk_dbuf && tweaks_seen == 1) want_fast = 1'b1;
          in_wait = 1'b0;
        end
        prev_tweak = core_ld_tweak;
        prev_busy  = core_busy;
      end
    end
  end

  task automatic send_word(input logic [15:0] d, input int gap_max);
    int t = 0;
    repeat ($urandom_range(0, gap_max)) @(negedge clk);
    hif.host_valid = 1'b1;
    hif.host_data  = d;
    while (!hif.host_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!hif.host_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL host_ready wait: got 0 after %0d cycles, required 1", t);
    end
    @(negedge clk);
    hif.host_valid = 1'b0;
    hif.host_data  = 16'($urandom);
  endtask

  task automatic wait_drain(input int limit);
    int t = 0;
    while (exp_q.size() != 0 && t < limit) begin
      @(negedge clk);
      t++;
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: got %0d events pending, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // pat: 0 random words, 1 ascending bytes 00,01,02.., 2 constant ABCD.
  task automatic run_hash(input logic [63:0] len, input int pat, input bit do_init, input int gap_max, input bit abort);
    int           nbytes, nwords, nblk, t;
    logic [15:0]  w[$];
    logic [7:0]   b[$];
    logic [255:0] blk;
    logic [15:0]  wd;
    nbytes = int'((len + 64'd7) / 64'd8);
    nwords = (nbytes + 1) / 2;
    for (int j = 0; j < nwords; j++) begin
      case (pat)
        1:       wd = {8'(2 * j + 1), 8'(2 * j)};
        2:       wd = 16'hABCD;
        default: wd = 16'($urandom);
      endcase
      w.push_back(wd);
    end
    for (int j = 0; j < nbytes; j++) begin
      wd = w[j / 2];
      b.push_back((j % 2 == 1) ? wd[15:8] : wd[7:0]);
    end
    nblk = (nbytes == 0) ? 1 : (nbytes + 31) / 32;
    if (do_init) begin
      push_ev(EV_INIT, '0);
      tweaks_seen = 0;
    end
    for (int i = 0; i < 4; i++) push_ev(EV_POSI, 256'(len[16 * (3 - i) +: 16]));
    for (int k = 0; k < nblk; k++) begin
      blk = '0;
      for (int i = 0; i < 32; i++)
        if (32 * k + i < nbytes) blk[8 * i +: 8] = b[32 * k + i];
      push_ev(EV_TWEAK, blk);
    end
    if (!abort) begin
      push_ev(EV_TWEAK, '0);
      push_ev(EV_DONE, '0);
    end
    if (do_init) begin
      hif.host_init = 1'b1;
      @(negedge clk);
      hif.host_init = 1'b0;
    end
    for (int i = 0; i < 4; i++) send_word(len[16 * (3 - i) +: 16], gap_max);
    for (int j = 0; j < nwords; j++) send_word(w[j], gap_max);
    if (abort) begin
      t = 0;
      while (!core_start && t < 500) begin
        @(negedge clk);
        t++;
      end
      chk("abort reached start", 256'(core_start), 256'd1);
      @(negedge clk);
      exp_q.delete();
      push_ev(EV_INIT, '0);
      hif.host_init  = 1'b1;
      hif.host_valid = 1'b1;
      hif.host_data  = 16'hDEAD;
      @(negedge clk);
      hif.host_init  = 1'b0;
      hif.host_valid = 1'b0;
      chk("ready in LEN after init", 256'(hif.host_ready), 256'd1);
    end else begin
      wait_drain(4000);
    end
  endtask

  initial begin
    hif.host_init  = 1'b0;
    hif.host_valid = 1'b0;
    hif.host_data  = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset controls", 256'({hash_done, core_init, core_ld_posi, core_idata, core_ld_tweak, core_start, hif.host_ready}), '0);
    chk("reset msg", {msg3, msg2, msg1, msg0}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    run_hash(64'h0, 0, 1'b1, 2, 1'b0);
    run_hash(64'h100, 1, 1'b1, 1, 1'b0);
    run_hash(64'h108, 0, 1'b1, 1, 1'b0);
    run_hash(64'h3, 2, 1'b1, 0, 1'b0);
    for (int r = 0; r < 6; r++) run_hash(64'($urandom_range(1, 1100)), 0, 1'b1, 2, 1'b0);

    // host_init in WAIT with a word offered: the word is dropped and a new length follows.
    run_hash(64'h100, 0, 1'b1, 0, 1'b1);
    run_hash(64'h30, 0, 1'b0, 1, 1'b0);

    // Asynchronous reset in the middle of a block fill.
    push_ev(EV_INIT, '0);
    for (int i = 0; i < 3; i++) push_ev(EV_POSI, '0);
    push_ev(EV_POSI, 256'h200);
    hif.host_init = 1'b1;
    @(negedge clk);
    hif.host_init = 1'b0;
    for (int i = 0; i < 3; i++) send_word(16'h0000, 0);
    send_word(16'h0200, 0);
    for (int j = 0; j < 5; j++) send_word(16'($urandom), 0);
    chk("ready mid fill", 256'(hif.host_ready), 256'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset controls", 256'({hash_done, core_init, core_ld_posi, core_idata, core_ld_tweak, core_start, hif.host_ready}), '0);
    chk("async reset msg", {msg3, msg2, msg1, msg0}, '0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_hash(64'($urandom_range(1, 600)), 0, 1'b1, 1, 1'b0);

`ifdef SKEIN_LDR_DBUF_EN
    busy_len = 24;
    chk_dbuf = 1'b1;
    run_hash(64'h200, 0, 1'b1, 0, 1'b0);
    chk_dbuf = 1'b0;
    busy_len = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
